// File: rtl/mar_pkg.sv
// Shared types and default widths for the burst-capable memory address register.
// Optional build macro: MAR_ALIGN_CHECK_EN (see mar_burst_gen).
package mar_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } mar_state_e;

    // Defaults shared with the legacy MAR and the memory port
    localparam int MAR_ADDR_W     = 32;
    localparam int MAR_LEN_W      = 8;
    localparam int MAR_WORD_BYTES = 4;

    // Shift amount that turns one beat into a byte-address increment
    function automatic int incr_shift(input int word_bytes);
        return $clog2(word_bytes);
    endfunction

endpackage

// File: rtl/mar_burst_gen_if.sv
// Control-unit / memory-port bundle for mar_burst_gen.
// Optional build macro: MAR_ALIGN_CHECK_EN adds align_err.
interface mar_burst_gen_if
    import mar_pkg::*;
#(
    parameter int ADDR_W = MAR_ADDR_W,
    parameter int LEN_W  = MAR_LEN_W
);
    // Load side: mar_write is taken only in a cycle where load_ready=1.
    // Beat side: a beat transfers on a rising edge with addr_valid & addr_ready;
    // address_out and last stay stable while addr_valid=1 and addr_ready=0.
    logic              mar_write;
    logic [ADDR_W-1:0] address_in;
    logic [LEN_W-1:0]  burst_len;
    logic              abort;
    logic              addr_ready;
    logic              load_ready;
    logic [ADDR_W-1:0] address_out;
    logic              addr_valid;
    logic              last;
    logic              busy;
    logic              done;
    mar_state_e        dbg_state;
`ifdef MAR_ALIGN_CHECK_EN
    logic              align_err;
`endif

    modport slave (
`ifdef MAR_ALIGN_CHECK_EN
        output align_err,
`endif
        input  mar_write, address_in, burst_len, abort, addr_ready,
        output load_ready, address_out, addr_valid, last, busy, done, dbg_state
    );

    modport master (
`ifdef MAR_ALIGN_CHECK_EN
        input  align_err,
`endif
        output mar_write, address_in, burst_len, abort, addr_ready,
        input  load_ready, address_out, addr_valid, last, busy, done, dbg_state
    );

endinterface

// File: rtl/mar_burst_gen.sv
// Memory address register that loads a base address and walks a burst of word addresses.
// Optional build macro: MAR_ALIGN_CHECK_EN rejects loads whose base is not word aligned.
module mar_burst_gen
    import mar_pkg::*;
#(
    parameter int ADDR_W     = MAR_ADDR_W,
    parameter int LEN_W      = MAR_LEN_W,
    parameter int WORD_BYTES = MAR_WORD_BYTES
) (
    input  logic           clk,
    input  logic           reset,
    mar_burst_gen_if.slave bus
);

    localparam int              SHIFT = incr_shift(WORD_BYTES);
    localparam logic [ADDR_W-1:0] INCR = ADDR_W'(1) << SHIFT;

    mar_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LEN_W-1:0]  rem_q,   rem_d;
    logic              done_q,  done_d;
    logic              misaligned;
`ifdef MAR_ALIGN_CHECK_EN
    logic              align_err_q, align_err_d;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = INCR - ADDR_W'(1);
    assign misaligned = |(bus.address_in & ALIGN_MASK);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            done_q      <= 1'b0;
`ifdef MAR_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            done_q      <= done_d;
`ifdef MAR_ALIGN_CHECK_EN
            align_err_q <= align_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
`ifdef MAR_ALIGN_CHECK_EN
        align_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.mar_write && !misaligned) begin
                    addr_d  = bus.address_in;
                    rem_d   = bus.burst_len;
                    state_d = BURST;
                end
`ifdef MAR_ALIGN_CHECK_EN
                align_err_d = bus.mar_write && misaligned;
`endif
            end
            BURST: begin
                // Abort wins over a same-cycle handshake: no increment, no done
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.addr_ready) begin
                    if (rem_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + INCR;
                        rem_d  = rem_q - LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready  = (state_q == IDLE);
        bus.addr_valid  = (state_q == BURST);
        bus.busy        = (state_q == BURST);
        bus.last        = (state_q == BURST) && (rem_q == '0);
        bus.address_out = addr_q;
        bus.done        = done_q;
        bus.dbg_state   = state_q;
`ifdef MAR_ALIGN_CHECK_EN
        bus.align_err   = align_err_q;
`endif
    end

endmodule

// File: tb/tb_mar_burst_gen.sv
// Directed bench for mar_burst_gen: per-cycle vector table plus hand-written reset/alignment sequences.
// Build with or without MAR_ALIGN_CHECK_EN to match the RTL.
module tb_mar_burst_gen;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    logic [31:0] exp_q[$];

    mar_burst_gen_if #(.ADDR_W(32), .LEN_W(8)) bus ();

    mar_burst_gen #(.ADDR_W(32), .LEN_W(8), .WORD_BYTES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        lr;
        logic [31:0] addr;
        logic        v;
        logic        last;
        logic        busy;
        logic        done;
        logic        mw;
        logic [31:0] ain;
        logic [7:0]  len;
        logic        ab;
        logic        rdy;
    } vec_t;

    vec_t tbl[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic lr, logic [31:0] addr, logic v, logic last, logic busy,
                                logic done, logic mw, logic [31:0] ain, logic [7:0] len,
                                logic ab, logic rdy);
        vec_t r;
        r.lr = lr; r.addr = addr; r.v = v; r.last = last; r.busy = busy; r.done = done;
        r.mw = mw; r.ain = ain; r.len = len; r.ab = ab; r.rdy = rdy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mw, input logic [31:0] ain, input logic [7:0] len,
                         input logic ab, input logic rdy);
        bus.mar_write  = mw;
        bus.address_in = ain;
        bus.burst_len  = len;
        bus.abort      = ab;
        bus.addr_ready = rdy;
    endtask

    // Any beat accepted at the coming edge must match the head of the expected queue
    task automatic score_beat(input string tag);
        if (bus.addr_valid && bus.addr_ready && !reset) begin
            if (exp_q.size() == 0) begin
                chk({tag, " unexpected_beat"}, bus.address_out, 32'hxxxx_xxxx);
            end else begin
                chk({tag, " beat_addr"}, bus.address_out, exp_q.pop_front());
            end
        end
    endtask

    task automatic run_row(input vec_t r, input int idx);
        string tag;
        @(negedge clk);
        tag = $sformatf("row%0d", idx);
        chk({tag, " load_ready"},  {31'd0, bus.load_ready}, {31'd0, r.lr});
        chk({tag, " address_out"}, bus.address_out, r.addr);
        chk({tag, " addr_valid"},  {31'd0, bus.addr_valid}, {31'd0, r.v});
        chk({tag, " last"},        {31'd0, bus.last}, {31'd0, r.last});
        chk({tag, " busy"},        {31'd0, bus.busy}, {31'd0, r.busy});
        chk({tag, " done"},        {31'd0, bus.done}, {31'd0, r.done});
        drive(r.mw, r.ain, r.len, r.ab, r.rdy);
        score_beat(tag);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);

        // lr  addr          v  last busy done | mw ain          len ab rdy
        tbl[0]  = mk(1, 32'h0000_0000, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 1);
        tbl[1]  = mk(0, 32'h1234_5678, 1, 1, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[2]  = mk(1, 32'h1234_5678, 0, 0, 0, 1, 0, 32'h0,         0, 0, 1);
        tbl[3]  = mk(1, 32'h1234_5678, 0, 0, 0, 0, 1, 32'h0000_1000, 3, 0, 1);
        tbl[4]  = mk(0, 32'h0000_1000, 1, 0, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[5]  = mk(0, 32'h0000_1004, 1, 0, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[6]  = mk(0, 32'h0000_1008, 1, 0, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[7]  = mk(0, 32'h0000_100C, 1, 1, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[8]  = mk(1, 32'h0000_100C, 0, 0, 0, 1, 1, 32'h0000_1000, 3, 0, 1);
        tbl[9]  = mk(0, 32'h0000_1000, 1, 0, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[10] = mk(0, 32'h0000_1004, 1, 0, 1, 0, 1, 32'h0000_5555, 1, 0, 0);
        tbl[11] = mk(0, 32'h0000_1004, 1, 0, 1, 0, 0, 32'h0,         0, 0, 0);
        tbl[12] = mk(0, 32'h0000_1004, 1, 0, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[13] = mk(0, 32'h0000_1008, 1, 0, 1, 0, 0, 32'h0,         0, 0, 0);
        tbl[14] = mk(0, 32'h0000_1008, 1, 0, 1, 0, 0, 32'h0,         0, 0, 0);
        tbl[15] = mk(0, 32'h0000_1008, 1, 0, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[16] = mk(0, 32'h0000_100C, 1, 1, 1, 0, 1, 32'h0000_6666, 2, 0, 0);
        tbl[17] = mk(0, 32'h0000_100C, 1, 1, 1, 0, 1, 32'h0000_7777, 2, 0, 1);
        tbl[18] = mk(1, 32'h0000_100C, 0, 0, 0, 1, 0, 32'h0,         0, 0, 0);
        tbl[19] = mk(1, 32'h0000_100C, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, 3, 0, 1);
        tbl[20] = mk(0, 32'hFFFF_FFF8, 1, 0, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[21] = mk(0, 32'hFFFF_FFFC, 1, 0, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[22] = mk(0, 32'h0000_0000, 1, 0, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[23] = mk(0, 32'h0000_0004, 1, 1, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[24] = mk(1, 32'h0000_0004, 0, 0, 0, 1, 0, 32'h0,         0, 1, 0);
        tbl[25] = mk(1, 32'h0000_0004, 0, 0, 0, 0, 1, 32'h0000_2000, 7, 0, 1);
        tbl[26] = mk(0, 32'h0000_2000, 1, 0, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[27] = mk(0, 32'h0000_2004, 1, 0, 1, 0, 0, 32'h0,         0, 0, 1);
        tbl[28] = mk(0, 32'h0000_2008, 1, 0, 1, 0, 0, 32'h0,         0, 1, 1);
        tbl[29] = mk(1, 32'h0000_2008, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0);
        tbl[30] = mk(1, 32'h0000_2008, 0, 0, 0, 0, 1, 32'h0000_3000, 5, 0, 0);
        tbl[31] = mk(0, 32'h0000_3000, 1, 0, 1, 0, 0, 32'h0,         0, 0, 0);

        exp_q = '{32'h1234_5678,
                  32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C,
                  32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C,
                  32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004,
                  32'h0000_2000, 32'h0000_2004, 32'h0000_2008};

        // Reset held for two cycles, checked while still asserted
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst load_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("rst address_out", bus.address_out, 32'h0);
        chk("rst addr_valid", {31'd0, bus.addr_valid}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) run_row(tbl[i], i);

        // Asynchronous reset in the middle of a burst, away from any clock edge
        #2;
        reset = 1'b1;
        #1;
        chk("midrst address_out", bus.address_out, 32'h0);
        chk("midrst addr_valid", {31'd0, bus.addr_valid}, 32'd0);
        chk("midrst busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst load_ready", {31'd0, bus.load_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'h0000_0002, 8'd1, 1'b0, 1'b1);

`ifdef MAR_ALIGN_CHECK_EN
        chk("align pre align_err", {31'd0, bus.align_err}, 32'd0);
        @(negedge clk);
        chk("align align_err", {31'd0, bus.align_err}, 32'd1);
        chk("align addr_valid", {31'd0, bus.addr_valid}, 32'd0);
        chk("align address_out", bus.address_out, 32'h0);
        chk("align load_ready", {31'd0, bus.load_ready}, 32'd1);
        drive(1'b0, 32'h0, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("align err_drop", {31'd0, bus.align_err}, 32'd0);
        chk("align still_idle", {31'd0, bus.addr_valid}, 32'd0);
`else
        exp_q.push_back(32'h0000_0002);
        exp_q.push_back(32'h0000_0006);
        @(negedge clk);
        chk("unal addr0", bus.address_out, 32'h0000_0002);
        chk("unal valid0", {31'd0, bus.addr_valid}, 32'd1);
        chk("unal last0", {31'd0, bus.last}, 32'd0);
        drive(1'b0, 32'h0, 8'd0, 1'b0, 1'b1);
        score_beat("unal0");
        @(negedge clk);
        chk("unal addr1", bus.address_out, 32'h0000_0006);
        chk("unal last1", {31'd0, bus.last}, 32'd1);
        score_beat("unal1");
        @(negedge clk);
        chk("unal done", {31'd0, bus.done}, 32'd1);
        chk("unal addr_hold", bus.address_out, 32'h0000_0006);
        chk("unal idle", {31'd0, bus.addr_valid}, 32'd0);
`endif

        chk("beats_left", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mar_burst_gen.md
Name: mar_burst_gen

Overview:
- Parametrised successor to the single-register memory address register.
- Holds a base address, then autonomously generates a burst of sequential word addresses toward the memory interface.
- Uses a valid/ready handshake per beat and supports abort.
- Sits between the control unit (which issues mar_write) and the memory/bus port; in IDLE it behaves as the plain MAR.

Parameters:
- ADDR_W, 32: address width in bits.
- LEN_W, 8: burst length field width; beats per burst = burst_len + 1 (1..2^LEN_W).
- WORD_BYTES, 4: address increment per beat; must be a power of two and ≥ 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mar_write  input  1  load request; accepted only when load_ready=1.
- address_in  input  ADDR_W  base address of the burst.
- burst_len  input  LEN_W  beats minus one, sampled with mar_write.
- abort  input  1  terminates an active burst.
- addr_ready  input  1  memory accepts the current beat.
- load_ready  output  1  high in IDLE (combinational from state).
- address_out  output  ADDR_W  current beat address (registered).
- addr_valid  output  1  current address is valid for the memory.
- last  output  1  current beat is the final one (remaining count = 0).
- busy  output  1  high in BURST.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (async assert) sets: state=IDLE, address_out=0, remaining=0, addr_valid=0, last=0, busy=0, done=0. load_ready=1 while in reset.
- IDLE:
  - mar_write=1 at a clock edge: address_out←address_in, remaining←burst_len, state→BURST.
  - The next cycle shows addr_valid=1, busy=1, and last=1 if burst_len=0. Load-to-first-valid latency is 1 cycle.
  - mar_write=0: address_out holds its value (plain MAR hold behaviour).
- BURST:
  - addr_valid stays high until the burst ends. address_out is stable while addr_ready=0.
  - Beat handshake (addr_valid & addr_ready) with remaining≠0: address_out←address_out+WORD_BYTES (wraps modulo 2^ADDR_W, no carry out), remaining←remaining−1. last rises when remaining reaches 0.
  - Handshake with remaining=0: state→IDLE, addr_valid→0, done=1 for exactly one cycle. address_out keeps the final beat address.
  - mar_write is ignored; load_ready=0.
- abort=1 in BURST:
  - state→IDLE next edge, addr_valid→0, no done pulse. address_out holds the current value with no increment.
  - Abort takes priority over a same-cycle handshake: the beat counts as issued, but no increment and no done.
  - abort in IDLE has no effect.
- Simultaneous mar_write and the final handshake: mar_write is ignored (load_ready=0 that cycle). A new burst may load on the cycle done is high.
- No back-to-back bursts without the intervening IDLE cycle.
- Async reset mid-burst: immediate return to reset values. The in-flight beat is lost.

Optional Feature:
- Macro MAR_ALIGN_CHECK_EN.
- Defined:
  - Adds output align_err (1 bit, reset 0).
  - mar_write with address_in[log2(WORD_BYTES)-1:0] ≠ 0 is rejected: no load, state stays IDLE, align_err=1 for one cycle.
- Undefined:
  - Port absent.
  - Unaligned addresses load as-is and increment unchanged.
- WORD_BYTES=1 makes the check a no-op in both cases.

Decomposition:
- Package mar_pkg:
  - state typedef (IDLE, BURST).
  - Localparam helper for the increment shift (log2 of WORD_BYTES).
  - Default width constants shared with the existing MAR and the memory port.
- Single module. The remaining-beat down-counter and the address incrementer stay inline; neither justifies a separate sub-module.

Test Plan:
1. Reset held 2 cycles, release → address_out=0, addr_valid=0, load_ready=1. Then mar_write, address_in=0x12345678, burst_len=0, addr_ready=1 → one beat at 0x12345678 with last=1, done pulses, address_out stays 0x12345678.
2. Load 0x00001000, burst_len=3, addr_ready=1 always → beats 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles; last only on 0x100C; done 1 cycle after.
3. Same burst with addr_ready toggling 1,0,0,1,… → address_out frozen while ready=0; exactly 4 handshakes total; mar_write pulsed mid-burst ignored.
4. Load 0xFFFFFFF8, burst_len=3 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004 (wrap).
5. Load 0x2000, burst_len=7, abort asserted together with the handshake on the 3rd beat (0x2008) → IDLE next cycle, addr_valid=0, no done, address_out=0x2008. Then reset asserted mid-burst → address_out=0 immediately.
6. With MAR_ALIGN_CHECK_EN defined: mar_write with 0x00000002 → align_err pulses, no load, addr_valid stays 0. Without the macro: same stimulus loads 0x2, beats 0x2, 0x6.
